// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and dmem_responder.
// Both channels transfer on a clock edge where valid && ready; a raised valid holds its payload until that edge.
interface dmem_responder_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_addr;
    logic                 req_wr_en;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [DataWidth-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_addr, req_wr_en, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wr_en, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte/half/word loads and stores on a word array.
// Define DMEM_RESPONDER_ERR_CHECK_EN to flag bad accesses; otherwise addresses are coerced and err stays 0.
module dmem_responder #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int DepthWords = 1024,
    parameter int WaitStates = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    dmem_responder_if.slave bus,
    output logic [1:0]      o_dbg_state
);
    localparam int IdxW = $clog2(DepthWords);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [AddrWidth-1:0] addr_q;
    logic                 wr_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 accept, do_access;

    logic [AddrWidth-1:0] a_addr, eff_addr;
    logic                 a_wr, a_uns, acc_err;
    logic [1:0]           a_size, eff_size, lane;
    logic [DataWidth-1:0] a_wdata, rd_word, wr_lanes, load_val;
    logic [IdxW-1:0]      word_idx;
    logic [3:0]           be;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;

    logic [DataWidth-1:0] mem [DepthWords];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        accept        = 1'b0;
        do_access     = 1'b0;
        bus.req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = i_rst_n;
                accept        = bus.req_valid && i_rst_n;
                if (accept) begin
                    if (WaitStates > 0) begin
                        state_d = WAIT;
                        cnt_d   = 3'(WaitStates - 1);
                    end else begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d   = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so use the live request.
    always_comb begin
        a_addr  = (state_q == IDLE) ? bus.req_addr     : addr_q;
        a_wr    = (state_q == IDLE) ? bus.req_wr_en    : wr_q;
        a_size  = (state_q == IDLE) ? bus.req_size     : size_q;
        a_uns   = (state_q == IDLE) ? bus.req_unsigned : uns_q;
        a_wdata = (state_q == IDLE) ? bus.req_wdata    : wdata_q;
    end

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    always_comb begin
        eff_addr = a_addr;
        eff_size = a_size;
        acc_err  = (a_size == 2'd3) ||
                   (a_size == 2'd1 && a_addr[0]) ||
                   (a_size == 2'd2 && a_addr[1:0] != 2'b00) ||
                   ((a_addr >> (IdxW + 2)) != '0);
    end
`else
    logic unused_hi;
    assign unused_hi = ^(a_addr >> (IdxW + 2));

    always_comb begin
        acc_err  = 1'b0;
        eff_addr = a_addr;
        eff_size = (a_size == 2'd3) ? 2'd2 : a_size;
        if (eff_size == 2'd1) eff_addr[0] = 1'b0;
        else if (eff_size == 2'd2) eff_addr[1:0] = 2'b00;
    end
`endif

    assign word_idx = eff_addr[IdxW+1:2];
    assign lane     = eff_addr[1:0];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
    assign rd_half  = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        be       = 4'b1111;
        wr_lanes = a_wdata;
        case (eff_size)
            2'd0: begin
                load_val = a_uns ? {{(DataWidth-8){1'b0}}, rd_byte}
                                 : {{(DataWidth-8){rd_byte[7]}}, rd_byte};
                be       = 4'b0001 << lane;
                wr_lanes = {4{a_wdata[7:0]}};
            end
            2'd1: begin
                load_val = a_uns ? {{(DataWidth-16){1'b0}}, rd_half}
                                 : {{(DataWidth-16){rd_half[15]}}, rd_half};
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{a_wdata[15:0]}};
            end
            default: ;
        endcase
        rdata_d = (a_wr || acc_err) ? '0 : load_val;
        err_d   = acc_err;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (do_access) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_q  <= bus.req_addr;
            wr_q    <= bus.req_wr_en;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata;
        end
    end

    // Reset gates the write so a store abandoned in WAIT never lands.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && do_access && a_wr && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign o_dbg_state   = state_q;
endmodule
